pickup_respawn_ctrl: RTL and testbench
======================================

Name: pickup_respawn_ctrl

Overview:
- Consumes the once-per-frame player/pickup hit pulse from the collision stage.
- Owns the pickup object's lifecycle: visible/hidden state, collect counter, respawn timer and spawn position.
- Output pickupVisible gates the pickup's drawing request. pickupTLX/pickupTLY feed the pickup's square/bitmap drawer. collectCount and collectStrobe feed the score and sound logic.

Parameters:
- RESPAWN_FRAMES, 120: frames the pickup stays hidden after collection; legal range 1..1023.
- COUNT_W, 8: width of collectCount.
- BLINK_FRAMES, 64: length of the post-respawn blink window; used only with the optional feature; legal range 0..1023.

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at the start of each video frame
- hitPulse  in  1  collision hit; high from the hit cycle until the next startOfFrame
- enable  in  1  game-running level; low forces IDLE
- clearCount  in  1  synchronous clear of collectCount
- pickupVisible  out  1  pickup may be drawn / collided with
- pickupTLX  out  11  top-left X of the pickup
- pickupTLY  out  11  top-left Y of the pickup
- collectCount  out  COUNT_W  pickups collected, saturating
- collectStrobe  out  1  one-cycle pulse per accepted collection

Behaviour:
- Clock and reset: one clock, clk. Reset resetN is asynchronous, active-low.
- Reset values:
  - state = IDLE, posIdx = 0, frameCnt = 0, hit_d = 0.
  - pickupVisible = 0, collectCount = 0, collectStrobe = 0.
  - pickupTLX = 100, pickupTLY = 100.
- Hit edge: hitEdge = hitPulse & ~hit_d, where hit_d is hitPulse registered every clock. Because hitPulse is a multi-cycle level, only its rising edge counts.
- Position table, indexed by posIdx (2 bits):
  - 0 = (100,100), 1 = (500,100), 2 = (100,380), 3 = (500,380).
  - pickupTLX/pickupTLY are registered from the table; they update the cycle after posIdx changes.
- FSM states: IDLE, ACTIVE, COLLECTED.
- IDLE:
  - pickupVisible = 0.
  - enable=1 and startOfFrame -> ACTIVE.
  - posIdx is retained.
- ACTIVE:
  - pickupVisible = 1.
  - hitEdge -> COLLECTED on the next clock. In that same clock: pickupVisible <= 0, collectStrobe <= 1 for exactly one cycle, collectCount increments, frameCnt <= 0.
- COLLECTED:
  - pickupVisible = 0; hitEdge is ignored.
  - frameCnt increments on each startOfFrame.
  - When startOfFrame arrives with frameCnt == RESPAWN_FRAMES-1: go to ACTIVE, posIdx <= posIdx+1 (wraps 3->0), frameCnt <= 0.
  - Hidden duration is therefore exactly RESPAWN_FRAMES frame starts.
- enable = 0 in any state:
  - Next clock: state = IDLE, pickupVisible = 0, frameCnt = 0.
  - Any pending hitEdge that cycle is dropped: no strobe, no count.
  - collectCount and posIdx are held.
- collectCount arithmetic:
  - Unsigned, saturates at 2^COUNT_W-1.
  - A hit at saturation still produces collectStrobe and the state change.
- clearCount:
  - Sets collectCount to 0 next clock.
  - Has priority over a simultaneous increment; collectStrobe still fires for that hit.
- Simultaneous startOfFrame and hitEdge in ACTIVE: the hit is accepted. frameCnt starts at 0 and that startOfFrame is not counted.
- Output timing: all outputs are registered; latency from hitEdge to outputs is 1 clock.
- Reset mid-operation: immediate return to reset values, including collectCount.

Optional Feature:
- Macro: PICKUP_BLINK_EN.
- With the macro defined:
  - After each COLLECTED->ACTIVE respawn, a blink window lasts BLINK_FRAMES frame starts.
  - During the window, pickupVisible = frame-counter bit 3, i.e. toggling every 8 frames and starting at 0.
  - hitEdge is accepted during the window only while pickupVisible = 1.
  - After the window, pickupVisible = 1 steadily.
  - The first entry from IDLE does not blink. BLINK_FRAMES = 0 disables the window.
- Without the macro: no blink logic, BLINK_FRAMES is unused, and pickupVisible = 1 throughout ACTIVE.

Test Plan:
1. Reset, enable=1, one startOfFrame -> state ACTIVE, pickupVisible=1, TL=(100,100), collectCount=0.
2. In ACTIVE, hitPulse high for 500 cycles -> exactly one collectStrobe one clock after the rise, collectCount=1, pickupVisible=0 one clock after the rise.
3. RESPAWN_FRAMES=3, after a hit send 3 startOfFrame -> pickupVisible returns to 1 on the clock after the 3rd, TL=(500,100). Four full cycles of collect and respawn -> TL wraps back to (100,100).
4. COUNT_W=2, 5 collections -> collectCount 1,2,3,3,3 and 5 strobes. Assert clearCount together with the 6th hit -> collectCount=0, strobe still fires.
5. Drop enable low mid-COLLECTED with frameCnt=2, while hitPulse rises that same cycle -> IDLE, no strobe, count held. Re-enable plus startOfFrame -> ACTIVE at the same posIdx.
6. PICKUP_BLINK_EN, BLINK_FRAMES=16:
   - After a respawn, pickupVisible=0 for frames 0-7 and 1 for frames 8-15, then steady 1.
   - A hit during frames 0-7 is ignored; a hit during frames 8-15 is accepted.

Source files
------------

// File: rtl/pickup_respawn_ctrl.sv
// Pickup lifecycle controller: visibility, collect counter, respawn timer and spawn position.
// Optional post-respawn blink window enabled by defining PICKUP_BLINK_EN.
module pickup_respawn_ctrl #(
    parameter int RESPAWN_FRAMES = 120,
    parameter int COUNT_W        = 8,
    parameter int BLINK_FRAMES   = 64
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               hitPulse,
    input  logic               enable,
    input  logic               clearCount,
    output logic               pickupVisible,
    output logic [10:0]        pickupTLX,
    output logic [10:0]        pickupTLY,
    output logic [COUNT_W-1:0] collectCount,
    output logic               collectStrobe
);

    if (RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 1023 ||
        BLINK_FRAMES < 0 || BLINK_FRAMES > 1023) begin : gParamCheck
        $error("pickup_respawn_ctrl: RESPAWN_FRAMES or BLINK_FRAMES out of range");
    end

    localparam logic [9:0] RESPAWN_LAST = 10'(RESPAWN_FRAMES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        COLLECTED = 2'd2
    } state_t;

    state_t             state;
    state_t             nextState;
    logic [1:0]         posIdx;
    logic [1:0]         posIdxNext;
    logic [9:0]         frameCnt;
    logic [9:0]         frameCntNext;
    logic               hit_d;
    logic               hitEdge;
    logic               hitWindowOk;
    logic               hitAccept;
    logic               visibleNext;
    logic               strobeNext;
    logic [COUNT_W-1:0] countNext;

    function automatic logic [COUNT_W-1:0] satInc(input logic [COUNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [10:0] posX(input logic [1:0] idx);
        return idx[0] ? 11'd500 : 11'd100;
    endfunction

    function automatic logic [10:0] posY(input logic [1:0] idx);
        return idx[1] ? 11'd380 : 11'd100;
    endfunction

    // Only the rising edge of the multi-cycle hit level is a collection attempt.
    assign hitEdge = hitPulse & ~hit_d;

`ifdef PICKUP_BLINK_EN
    localparam logic [9:0] BLINK_LAST = 10'(BLINK_FRAMES - 1);
    localparam logic       BLINK_USE  = (BLINK_FRAMES != 0);

    logic       blinkOn;
    logic       blinkOnNext;
    logic [9:0] blinkCnt;
    logic [9:0] blinkCntNext;

    // While blinking, a hit only counts when the pickup is actually shown.
    assign hitWindowOk = ~blinkOn | pickupVisible;
`else
    assign hitWindowOk = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            posIdx   <= 2'd0;
            frameCnt <= 10'd0;
            hit_d    <= 1'b0;
`ifdef PICKUP_BLINK_EN
            blinkOn  <= 1'b0;
            blinkCnt <= 10'd0;
`endif
        end else begin
            state    <= nextState;
            posIdx   <= posIdxNext;
            frameCnt <= frameCntNext;
            hit_d    <= hitPulse;
`ifdef PICKUP_BLINK_EN
            blinkOn  <= blinkOnNext;
            blinkCnt <= blinkCntNext;
`endif
        end
    end

    always_comb begin
        nextState    = state;
        posIdxNext   = posIdx;
        frameCntNext = frameCnt;
        hitAccept    = 1'b0;
        if (!enable) begin
            nextState    = IDLE;
            frameCntNext = 10'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (startOfFrame) nextState = ACTIVE;
                end
                ACTIVE: begin
                    // A hit coinciding with a frame start wins; that frame start is not counted.
                    if (hitEdge && hitWindowOk) begin
                        hitAccept    = 1'b1;
                        nextState    = COLLECTED;
                        frameCntNext = 10'd0;
                    end
                end
                COLLECTED: begin
                    if (startOfFrame) begin
                        if (frameCnt == RESPAWN_LAST) begin
                            nextState    = ACTIVE;
                            posIdxNext   = posIdx + 2'd1;
                            frameCntNext = 10'd0;
                        end else begin
                            frameCntNext = frameCnt + 10'd1;
                        end
                    end
                end
                default: nextState = IDLE;
            endcase
        end
    end

`ifdef PICKUP_BLINK_EN
    always_comb begin
        blinkOnNext  = blinkOn;
        blinkCntNext = blinkCnt;
        if (nextState != ACTIVE) begin
            blinkOnNext  = 1'b0;
            blinkCntNext = 10'd0;
        end else if (state == COLLECTED) begin
            blinkOnNext  = BLINK_USE;
            blinkCntNext = 10'd0;
        end else if (blinkOn && startOfFrame) begin
            if (blinkCnt == BLINK_LAST) begin
                blinkOnNext = 1'b0;
            end else begin
                blinkCntNext = blinkCnt + 10'd1;
            end
        end
    end
`endif

    always_comb begin
        visibleNext = (nextState == ACTIVE);
`ifdef PICKUP_BLINK_EN
        if (blinkOnNext && !blinkCntNext[3]) visibleNext = 1'b0;
`endif
        strobeNext = hitAccept;
        if (clearCount) begin
            countNext = '0;
        end else if (hitAccept) begin
            countNext = satInc(collectCount);
        end else begin
            countNext = collectCount;
        end
    end

    // Position registers follow posIdx one cycle later.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pickupVisible <= 1'b0;
            collectStrobe <= 1'b0;
            collectCount  <= '0;
            pickupTLX     <= 11'd100;
            pickupTLY     <= 11'd100;
        end else begin
            pickupVisible <= visibleNext;
            collectStrobe <= strobeNext;
            collectCount  <= countNext;
            pickupTLX     <= posX(posIdx);
            pickupTLY     <= posY(posIdx);
        end
    end

endmodule

// File: tb/tb_pickup_respawn_ctrl.sv
// Directed bench for pickup_respawn_ctrl with a frame-level reference model checked every cycle.
module tb_pickup_respawn_ctrl;

    localparam int RESP  = 3;
    localparam int CW    = 2;
    localparam int BLINK = 16;
    localparam int MAXC  = (1 << CW) - 1;
`ifdef PICKUP_BLINK_EN
    localparam bit BLINK_ON = 1'b1;
`else
    localparam bit BLINK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetN;
    logic          startOfFrame;
    logic          hitPulse;
    logic          enable;
    logic          clearCount;
    logic          pickupVisible;
    logic [10:0]   pickupTLX;
    logic [10:0]   pickupTLY;
    logic [CW-1:0] collectCount;
    logic          collectStrobe;

    int errors = 0;
    int checks = 0;
    int strobeSeen = 0;

    pickup_respawn_ctrl #(
        .RESPAWN_FRAMES(RESP),
        .COUNT_W       (CW),
        .BLINK_FRAMES  (BLINK)
    ) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .hitPulse     (hitPulse),
        .enable       (enable),
        .clearCount   (clearCount),
        .pickupVisible(pickupVisible),
        .pickupTLX    (pickupTLX),
        .pickupTLY    (pickupTLY),
        .collectCount (collectCount),
        .collectStrobe(collectStrobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 shown, 2 hidden; mBlink = frames since respawn or -1.
    int mMode, mPos, mTlPos, mHidden, mBlink, mCount;
    bit mStrobe, mVis, mHitPrev, hitE, acc;

    function automatic int tlX(input int p);
        return (p % 2 == 1) ? 500 : 100;
    endfunction

    function automatic int tlY(input int p);
        return (p >= 2) ? 380 : 100;
    endfunction

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mMode = 0; mPos = 0; mTlPos = 0; mHidden = 0; mBlink = -1;
            mCount = 0; mStrobe = 0; mVis = 0; mHitPrev = 0;
        end else begin
            hitE = hitPulse && !mHitPrev;
            mHitPrev = hitPulse;
            acc = 0;
            mTlPos = mPos;
            if (!enable) begin
                mMode = 0; mHidden = 0; mBlink = -1;
            end else if (mMode == 0) begin
                if (startOfFrame) begin mMode = 1; mBlink = -1; end
            end else if (mMode == 1) begin
                if (hitE && mVis) begin
                    acc = 1; mMode = 2; mHidden = 0; mBlink = -1;
                end else if (startOfFrame && mBlink >= 0) begin
                    mBlink++;
                    if (mBlink >= BLINK) mBlink = -1;
                end
            end else begin
                if (startOfFrame) begin
                    mHidden++;
                    if (mHidden == RESP) begin
                        mMode = 1; mHidden = 0; mPos = (mPos + 1) % 4;
                        mBlink = (BLINK_ON && BLINK > 0) ? 0 : -1;
                    end
                end
            end
            if (clearCount) mCount = 0;
            else if (acc && mCount < MAXC) mCount++;
            mStrobe = acc;
            mVis = (mMode == 1) && (mBlink < 0 || ((mBlink >> 3) & 1) == 1);
        end
    end

    always @(posedge clk) begin
        #2;
        check("visible", pickupVisible, mVis);
        check("strobe", collectStrobe, mStrobe);
        check("count", collectCount, mCount);
        check("tlx", pickupTLX, tlX(mTlPos));
        check("tly", pickupTLY, tlY(mTlPos));
        if (collectStrobe === 1'b1) strobeSeen++;
    end

    task automatic sofPulse();
        startOfFrame = 1'b1;
        hitPulse = 1'b0;
        @(negedge clk);
        startOfFrame = 1'b0;
    endtask

    task automatic collectAndRespawn();
        hitPulse = 1'b1;
        @(negedge clk);
        repeat (RESP) sofPulse();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    int s0;
    int expCnt[5] = '{1, 2, 3, 3, 3};

    initial begin
        resetN = 1'b0; startOfFrame = 1'b0; hitPulse = 1'b0; enable = 1'b0; clearCount = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_visible", pickupVisible, 0);
        check("rst_count", collectCount, 0);
        check("rst_tlx", pickupTLX, 100);
        check("rst_tly", pickupTLY, 100);
        resetN = 1'b1;
        @(negedge clk);

        // Enter play
        enable = 1'b1;
        @(negedge clk);
        sofPulse();
        check("t1_visible", pickupVisible, 1);
        check("t1_tlx", pickupTLX, 100);
        check("t1_count", collectCount, 0);

        // Long hit level gives one collection
        s0 = strobeSeen;
        hitPulse = 1'b1;
        @(negedge clk);
        check("t2_strobe", collectStrobe, 1);
        check("t2_count", collectCount, 1);
        check("t2_visible", pickupVisible, 0);
        repeat (499) @(negedge clk);
        check("t2_one_strobe", strobeSeen - s0, 1);

        // Respawn after RESP frame starts, then wrap positions
        sofPulse();
        sofPulse();
        check("t3_hidden", pickupVisible, 0);
        sofPulse();
        check("t3_respawn_vis", pickupVisible, 1);
        @(negedge clk);
        check("t3_tlx", pickupTLX, 500);
        check("t3_tly", pickupTLY, 100);
        repeat (3) collectAndRespawn();
        check("t3_wrap_tlx", pickupTLX, 100);
        check("t3_wrap_tly", pickupTLY, 100);

        // Saturating count and clear priority
        clearCount = 1'b1;
        @(negedge clk);
        clearCount = 1'b0;
        check("t4_cleared", collectCount, 0);
        s0 = strobeSeen;
        for (int i = 0; i < 5; i++) begin
            hitPulse = 1'b1;
            @(negedge clk);
            check("t4_count_seq", collectCount, expCnt[i]);
            repeat (RESP) sofPulse();
        end
        check("t4_five_strobes", strobeSeen - s0, 5);
        hitPulse = 1'b1;
        clearCount = 1'b1;
        @(negedge clk);
        clearCount = 1'b0;
        check("t4_clear_strobe", collectStrobe, 1);
        check("t4_clear_count", collectCount, 0);

        // Disable while hidden with frameCnt=2
        sofPulse();
        sofPulse();
        enable = 1'b0;
        hitPulse = 1'b1;
        @(negedge clk);
        check("t5_off_strobe", collectStrobe, 0);
        check("t5_off_visible", pickupVisible, 0);
        check("t5_off_count", collectCount, 0);
        enable = 1'b1;
        @(negedge clk);
        sofPulse();
        check("t5_reenter_vis", pickupVisible, 1);
        @(negedge clk);
        check("t5_same_pos_x", pickupTLX, 500);
        check("t5_same_pos_y", pickupTLY, 100);

        // Disable while shown drops a simultaneous hit
        enable = 1'b0;
        hitPulse = 1'b1;
        @(negedge clk);
        check("t5_drop_strobe", collectStrobe, 0);
        check("t5_drop_count", collectCount, 0);
        enable = 1'b1;
        @(negedge clk);
        sofPulse();

        // Hit and frame start together: hit wins, frame start not counted
        hitPulse = 1'b1;
        startOfFrame = 1'b1;
        @(negedge clk);
        startOfFrame = 1'b0;
        check("sim_strobe", collectStrobe, 1);
        check("sim_count", collectCount, 1);
        sofPulse();
        sofPulse();
        check("sim_still_hidden", pickupVisible, 0);
        sofPulse();
        check("sim_respawn", pickupVisible, 1);
        @(negedge clk);
        check("sim_tlx", pickupTLX, 100);
        check("sim_tly", pickupTLY, 380);

        // Asynchronous reset mid-operation
        #2 resetN = 1'b0;
        #1;
        check("arst_count", collectCount, 0);
        check("arst_visible", pickupVisible, 0);
        check("arst_tly", pickupTLY, 100);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);

`ifdef PICKUP_BLINK_EN
        sofPulse();
        check("b_first_entry_vis", pickupVisible, 1);
        hitPulse = 1'b1;
        @(negedge clk);
        check("b_hit1", collectStrobe, 1);
        repeat (RESP) sofPulse();
        check("b_frame0_vis", pickupVisible, 0);
        hitPulse = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b_ignored_hit", collectStrobe, 0);
        check("b_ignored_vis", pickupVisible, 0);
        repeat (7) sofPulse();
        check("b_frame7_vis", pickupVisible, 0);
        sofPulse();
        check("b_frame8_vis", pickupVisible, 1);
        hitPulse = 1'b1;
        @(negedge clk);
        check("b_accepted_hit", collectStrobe, 1);
        repeat (RESP) sofPulse();
        repeat (BLINK) sofPulse();
        check("b_steady_vis", pickupVisible, 1);
        sofPulse();
        check("b_steady_vis2", pickupVisible, 1);
`endif

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
